vidclk_sequencer: RTL

VIDCLK_SEQUENCER -- requirements
Module: vidclk_sequencer

---
 rtl/amigaclks_pkg.sv | 28 ++
 rtl/sync2.sv | 34 +++
 rtl/vidclk_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/amigaclks_pkg.sv
// Shared definitions for the Amiga clocking blocks: sequencer state encoding
// and the default timing constants used by vidclk_sequencer.
package amigaclks_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_BLANK     = 3'd1,
    ST_DROP      = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_FAULT     = 3'd5
  } vs_state_e;

  localparam int unsigned DEF_SETTLE_CYC   = 64;
  localparam int unsigned DEF_DROP_CYC     = 256;
  localparam int unsigned DEF_LOCK_STABLE  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT = 1048576;
  localparam int unsigned DEF_MAX_RETRY    = 3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow, level-type status signals crossing into
// the local clock domain. Each bit is synchronized independently.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes this a 2-stage chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vidclk_sequencer.sv
// Sequences TMDS PLL mode switches: blanks the pixel domain, reprograms the
// PLL divider select, and holds video_reset until lock is qualified stable.
module vidclk_sequencer
  import amigaclks_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned DROP_CYC     = DEF_DROP_CYC,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic clk_28m,
  input  logic reset,
  input  logic vidmode_req,
  input  logic video_locked,
  output logic vidmode,
  output logic video_reset,
  output logic busy,
  output logic fault
);

  // One shared cycle counter covers BLANK, DROP and the WAIT_LOCK timeout,
  // since those never run at the same time.
  localparam int unsigned CNT_MAX = max3(SETTLE_CYC, DROP_CYC, LOCK_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DROP_LAST    = CNT_W'(DROP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STABLE_SAT   = STB_W'(LOCK_STABLE);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRY);

  logic lock_s;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk_28m),
    .reset (reset),
    .d     (video_locked),
    .q     (lock_s)
  );

  vs_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  logic             vidmode_q, vidmode_d;
  logic             video_reset_q, video_reset_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    vidmode_d = vidmode_q;
    retry_d   = retry_q;
    stable_d  = '0;
    cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    unique case (state_q)
      ST_RUN: begin
        if (vidmode_req != vidmode_q) begin
          state_d = ST_BLANK;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_BLANK: begin
        if (cnt_q == SETTLE_LAST) begin
          vidmode_d = vidmode_req;
          state_d   = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!lock_s || cnt_q == DROP_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          stable_d = (stable_q == STABLE_SAT) ? stable_q : stable_q + 1'b1;
        end
        // A qualified lock wins over a timeout landing on the same cycle.
        if (stable_d == STABLE_SAT) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RETRY_MAX) ? ST_BLANK : ST_FAULT;
        end
      end
      ST_RELEASE: begin
        retry_d = '0;
        state_d = ST_RUN;
      end
      ST_FAULT: begin
        if (vidmode_req != vidmode_q) begin
          retry_d = '0;
          state_d = ST_BLANK;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, with no input-to-output path.
    video_reset_d = (state_d != ST_RUN);
    busy_d        = (state_d != ST_RUN);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_28m) begin
    if (reset) begin
      state_q       <= ST_WAIT_LOCK;
      vidmode_q     <= 1'b1;
      video_reset_q <= 1'b1;
      busy_q        <= 1'b1;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      vidmode_q     <= vidmode_d;
      video_reset_q <= video_reset_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      retry_q       <= retry_d;
    end
  end

  assign vidmode     = vidmode_q;
  assign video_reset = video_reset_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule
